// File: rtl/mul_add_seq.sv
// Sequential shift-and-add multiply-accumulate: product = multiplicand*multiplier + addend,
// one multiplier bit per clock, with an optional compare against a latched expected value.
module mul_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    input  logic [2*WIDTH-1:0]   expected,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic                 match
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [PW-1:0]   mcand_sh;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]   exp_r;
    logic [CW-1:0]   count;
    logic            accept;
    logic            last_step;

    // Handshake: start is sampled on every rising edge but only taken when not busy
    // (IDLE or DONE); done stays high from completion until the next accepted start.
    assign accept    = start && (state != S_RUN);
    assign last_step = (state == S_RUN) && (count == CW'(WIDTH - 1));
    assign acc_next  = mplier[0] ? (acc + mcand_sh) : acc;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A fixed WIDTH steps run regardless of operand values, so latency never varies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            exp_r    <= '0;
            count    <= '0;
            product  <= '0;
            match    <= 1'b0;
        end else if (accept) begin
            acc      <= {{WIDTH{1'b0}}, addend};
            mcand_sh <= {{WIDTH{1'b0}}, multiplicand};
            mplier   <= multiplier;
            exp_r    <= expected;
            count    <= '0;
            match    <= 1'b0;
        end else if (state == S_RUN) begin
            acc      <= acc_next;
            mcand_sh <= mcand_sh << 1;
            mplier   <= mplier >> 1;
            count    <= count + CW'(1);
            if (last_step) begin
                product <= acc_next;
                match   <= (acc_next == exp_r);
            end
        end
    end

endmodule

// File: tb/tb_mul_add_seq.sv
// Bench for mul_add_seq: directed vector table, multi-cycle corner sequences and
// randomized operations scored against an arithmetic reference model.
module tb_mul_add_seq;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic [W-1:0]  addend;
    logic [PW-1:0] expected;
    logic [PW-1:0] product;
    logic          busy;
    logic          done;
    logic          match;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PW-1:0] exp_q[$];
    logic          exp_m_q[$];

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  c;
        logic [PW-1:0] e;
        logic [PW-1:0] prod;
        logic          m;
    } vec_t;

    vec_t vecs[6];

    mul_add_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .expected     (expected),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .match        (match)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] model(input int a, input int b, input int c);
        int r;
        r = a * b + c;
        return r[PW-1:0];
    endfunction

    // Drive a start pulse, then wait for done while scrambling the inputs; returns
    // the number of edges from acceptance to done and whether busy/done overlapped.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [PW-1:0] e, output int cycles, output bit overlap);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        expected     = e;
        start        = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        overlap = busy && done;
        check("busy_after_accept", busy, 1'b1);
        cycles = 0;
        while (!done && cycles < 30) begin
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            addend       = W'($urandom);
            expected     = PW'($urandom);
            @(negedge clk);
            cycles++;
            if (busy && done) overlap = 1'b1;
        end
    endtask

    initial begin
        int    cyc;
        bit    ovl;
        bit    saw_done;
        logic [PW-1:0] p_hold;
        logic [PW-1:0] second;
        logic [W-1:0]  ra, rb, rc;
        logic [PW-1:0] re;

        vecs[0] = '{a: 4'd13, b: 4'd11, c: 4'd5,  e: 8'd148, prod: 8'd148, m: 1'b1};
        vecs[1] = '{a: 4'd4,  b: 4'd3,  c: 4'd2,  e: 8'd14,  prod: 8'd14,  m: 1'b1};
        vecs[2] = '{a: 4'd4,  b: 4'd3,  c: 4'd2,  e: 8'd15,  prod: 8'd14,  m: 1'b0};
        vecs[3] = '{a: 4'd15, b: 4'd15, c: 4'd15, e: 8'd240, prod: 8'd240, m: 1'b1};
        vecs[4] = '{a: 4'd0,  b: 4'd9,  c: 4'd0,  e: 8'd1,   prod: 8'd0,   m: 1'b0};
        vecs[5] = '{a: 4'd7,  b: 4'd0,  c: 4'd9,  e: 8'd9,   prod: 8'd9,   m: 1'b1};

        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;
        expected     = '0;
        repeat (3) @(negedge clk);
        check("reset_product", product, 0);
        check("reset_busy",    busy,    0);
        check("reset_done",    done,    0);
        check("reset_match",   match,   0);
        reset_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e, cyc, ovl);
            check($sformatf("vec%0d_latency", i), cyc, W);
            check($sformatf("vec%0d_product", i), product, vecs[i].prod);
            check($sformatf("vec%0d_match", i), match, vecs[i].m);
            check($sformatf("vec%0d_busy", i), busy, 0);
            check($sformatf("vec%0d_overlap", i), ovl, 0);
        end

        // start held high through RUN: first result must be untouched, and the
        // start coincident with DONE is accepted
        @(negedge clk);
        multiplicand = 4'd13; multiplier = 4'd11; addend = 4'd5; expected = 8'd148;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            multiplicand = W'(k + 1); multiplier = W'(k + 2); addend = W'(k);
        end
        @(negedge clk);
        check("ignore_start_done",    done,    1);
        check("ignore_start_product", product, 148);
        multiplicand = 4'd6; multiplier = 4'd5; addend = 4'd3; expected = 8'd33;
        second = model(6, 5, 3);
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_falls", done, 0);
        check("b2b_busy",       busy, 1);
        check("b2b_product_kept", product, 148);
        repeat (3) @(negedge clk);
        check("b2b_not_early", done, 0);
        @(negedge clk);
        check("b2b_done",    done,    1);
        check("b2b_product", product, second);
        check("b2b_match",   match,   1);

        // reset two cycles into RUN
        @(negedge clk);
        multiplicand = 4'd13; multiplier = 4'd11; addend = 4'd5; expected = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrun_rst_product", product, 0);
        check("midrun_rst_busy",    busy,    0);
        check("midrun_rst_done",    done,    0);
        check("midrun_rst_match",   match,   0);
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("midrun_no_done", saw_done, 0);
        run_op(4'd2, 4'd3, 4'd1, 8'd7, cyc, ovl);
        check("after_rst_product", product, 7);
        check("after_rst_match",   match,   1);
        check("after_rst_latency", cyc,     W);

        // hold in DONE
        p_hold = product;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_product", product, 7);
            check("hold_done",    done,    1);
            check("hold_match",   match,   1);
        end

        // randomized operations against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rc = W'($urandom_range(0, (1 << W) - 1));
            re = model(int'(ra), int'(rb), int'(rc));
            if ($urandom_range(0, 1) == 1) re = re ^ PW'($urandom_range(1, (1 << PW) - 1));
            exp_q.push_back(model(int'(ra), int'(rb), int'(rc)));
            exp_m_q.push_back(re == model(int'(ra), int'(rb), int'(rc)));
            run_op(ra, rb, rc, re, cyc, ovl);
            check("rand_latency", cyc, W);
            check("rand_overlap", ovl, 0);
            check("rand_product", product, exp_q.pop_front());
            check("rand_match",   match,   exp_m_q.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_add_seq.md
Name: mul_add_seq

Overview:
Sequential shift-and-add multiply-accumulate unit that computes product = multiplicand*multiplier + addend, one multiplier bit per clock. It is the inverse-direction companion of the sequential divider and uses the same start/done handshake. Feeding it quotient, divisor and remainder reconstructs the dividend. An optional expected-value compare turns it into a self-check for divider results.

Parameters:
WIDTH, 4, operand width in bits (>=2); product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled on clk rise; accepted only when not busy
multiplicand  input  WIDTH  operand A (unsigned), latched on accepted start
multiplier  input  WIDTH  operand B (unsigned), latched on accepted start
addend  input  WIDTH  accumulate term C (unsigned), latched on accepted start
expected  input  2*WIDTH  compare value, latched on accepted start
product  output  2*WIDTH  A*B+C, registered, updated only on completion
busy  output  1  high while computing
done  output  1  high from completion until next accepted start
match  output  1  registered (product == latched expected), valid while done=1

Behaviour:
- Reset (reset_n=0, async): product=0, busy=0, done=0, match=0. State=IDLE. Count=0. Internal operand registers=0. Takes effect immediately, including mid-operation. The abandoned operation produces no done.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start=1: accept. Latch operands: acc = zero-extended addend, mcand_sh = zero-extended multiplicand, mplier = multiplier, exp = expected, count=0. Set busy=1, done=0, match=0. Go to RUN. product keeps its old value.
  - RUN, each edge:
    - if mplier[0], acc <= acc + mcand_sh (2*WIDTH-bit add).
    - mcand_sh <<= 1; mplier >>= 1; count += 1.
    - When the step with count==WIDTH-1 executes, that edge also sets product=final acc, match=(final acc==exp), busy=0, done=1, and goes to DONE.
  - RUN + start=1: ignored. No restart, no effect on operands.
- Latency: start accepted at edge N -> busy=1 after edge N. done=1 and product valid after edge N+WIDTH. Exactly WIDTH RUN cycles, independent of operand values (no early exit on zero).
- Throughput: start asserted during DONE is accepted on that edge, so back-to-back operations take WIDTH+1 cycles each. done drops the cycle after acceptance.
- Width rule: max result (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so it always fits 2*WIDTH bits. No overflow or carry-out exists.
- Operands are unsigned. Input changes after acceptance have no effect.
- count width is clog2(WIDTH+1). busy and done are never high simultaneously.
- DONE without start: hold product, match and done=1 indefinitely.

Test Plan:
- WIDTH=4, reset, start with A=13, B=11, C=5 -> busy for 4 cycles, then product=148 (0x94), done=1, busy=0.
- Divider reconstruct: A=4 (quotient), B=3 (divisor), C=2 (remainder), expected=14 -> product=14, match=1. Repeat with expected=15 -> match=0.
- Extremes: A=15, B=15, C=15 -> product=240 (0xF0). A=0, B=9, C=0 -> product=0 after exactly 4 cycles. A=7, B=0, C=9 -> product=9.
- Start pulses every cycle during RUN with different operands -> first operation's result is unchanged (13*11+5=148). The start coincident with DONE is accepted: done falls next cycle, new result after 4 further cycles.
- reset_n pulled low 2 cycles into RUN -> all outputs 0 immediately and no done. After release, a fresh start with 2*3+1 -> product=7.
- Hold: after done, start=0 for 10 cycles -> product, match and done stay constant.
